// File: rtl/bytecode_translator_if.sv
// Byte-stream input and ARM-word output handshakes of the bytecode translator.
// The translator connects through the slave modport; the bytecode source / word sink use master.
interface bytecode_translator_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] out_word;
  logic                  out_ready;

  modport master (
    output byte_valid, byte_data, out_ready,
    input  byte_ready, out_valid, out_word
  );

  modport slave (
    input  byte_valid, byte_data, out_ready,
    output byte_ready, out_valid, out_word
  );
endinterface

// File: rtl/bytecode_translator.sv
// Translates a JVM-style bytecode stream into ARM words via an external opcode table and template ROM.
// Optional wide-operand prefix (0xC4) enabled by defining BYTECODE_TRANSLATOR_WIDE_PREFIX_EN.
module bytecode_translator #(
  parameter int WORD_WIDTH  = 32,
  parameter int TADDR_WIDTH = 8,
  parameter int MAX_PARAMS  = 4,
  localparam int PCW        = $clog2(MAX_PARAMS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  bytecode_translator_if.slave   bus,
  output logic [7:0]             lk_opcode,
  input  logic [PCW-1:0]         lk_param_count,
  input  logic [TADDR_WIDTH-1:0] lk_template,
  output logic [TADDR_WIDTH-1:0] tmpl_addr,
  input  logic [WORD_WIDTH-1:0]  tmpl_word,
  input  logic [TADDR_WIDTH-1:0] tmpl_next,
  output logic                   operand_valid,
  output logic [15:0]            operand_value,
  output logic                   busy
);

  typedef enum logic [2:0] {
    FETCH_OP,
    LOOKUP,
    FETCH_PARAM,
    PUSH,
    LOAD_WORD,
    EMIT
  } state_t;

  state_t                 state, next_state;
  logic [PCW-1:0]         counter;
  logic [TADDR_WIDTH-1:0] ptr;
  logic [TADDR_WIDTH-1:0] nxt;
  logic [WORD_WIDTH-1:0]  out_word_q;
  logic                   byte_xfer;
  logic                   out_xfer;

`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
  localparam logic [7:0] WIDE_PREFIX = 8'hC4;
  logic wide;
  logic half;
`endif

  assign bus.byte_ready = (state == FETCH_OP) || (state == FETCH_PARAM);
  assign bus.out_valid  = (state == EMIT);
  assign bus.out_word   = out_word_q;
  assign operand_valid  = (state == PUSH);
  assign busy           = (state != FETCH_OP);
  assign tmpl_addr      = ptr;
  assign byte_xfer      = bus.byte_valid && bus.byte_ready;
  assign out_xfer       = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_OP;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH_OP: if (byte_xfer) next_state = LOOKUP;
      LOOKUP: begin
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
        if (lk_opcode == WIDE_PREFIX) next_state = FETCH_OP;
        else
`endif
        if (lk_param_count != '0) next_state = FETCH_PARAM;
        else                      next_state = LOAD_WORD;
      end
      FETCH_PARAM: begin
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
        // A wide operand is complete only once its low byte has arrived
        if (byte_xfer && (!wide || half)) next_state = PUSH;
`else
        if (byte_xfer) next_state = PUSH;
`endif
      end
      PUSH:      next_state = (counter != PCW'(1)) ? FETCH_PARAM : LOAD_WORD;
      LOAD_WORD: next_state = (ptr == '0) ? FETCH_OP : EMIT;
      EMIT: begin
        if (out_xfer) next_state = (nxt == '0) ? FETCH_OP : LOAD_WORD;
      end
      default:   next_state = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_opcode     <= '0;
      counter       <= '0;
      ptr           <= '0;
      nxt           <= '0;
      out_word_q    <= '0;
      operand_value <= '0;
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
      wide          <= 1'b0;
      half          <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH_OP: if (byte_xfer) lk_opcode <= bus.byte_data;
        LOOKUP: begin
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
          if (lk_opcode == WIDE_PREFIX) wide <= 1'b1;
          else begin
`else
          begin
`endif
            counter <= lk_param_count;
            ptr     <= lk_template;
          end
        end
        FETCH_PARAM: begin
          if (byte_xfer) begin
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
            // Wide operands arrive big-endian: high byte first
            if (wide) begin
              if (!half) operand_value[15:8] <= bus.byte_data;
              else       operand_value[7:0]  <= bus.byte_data;
              half <= !half;
            end else begin
              operand_value <= {8'h00, bus.byte_data};
            end
`else
            operand_value <= {8'h00, bus.byte_data};
`endif
          end
        end
        PUSH: counter <= counter - PCW'(1);
        LOAD_WORD: begin
          if (ptr != '0) begin
            out_word_q <= tmpl_word;
            nxt        <= tmpl_next;
          end
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
          else wide <= 1'b0;
`endif
        end
        EMIT: begin
          if (out_xfer) begin
            ptr <= nxt;
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
            if (nxt == '0) wide <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_translator.sv
// Scoreboard bench for bytecode_translator: directed byte streams, expected operands/words queued,
// a negedge monitor compares every operand push and word transfer.
module tb_bytecode_translator;

  localparam int WORD_WIDTH  = 32;
  localparam int TADDR_WIDTH = 8;
  localparam int PCW         = 3;

  logic                   clk;
  logic                   rst;
  logic [7:0]             lk_opcode;
  logic [PCW-1:0]         lk_param_count;
  logic [TADDR_WIDTH-1:0] lk_template;
  logic [TADDR_WIDTH-1:0] tmpl_addr;
  logic [WORD_WIDTH-1:0]  tmpl_word;
  logic [TADDR_WIDTH-1:0] tmpl_next;
  logic                   operand_valid;
  logic [15:0]            operand_value;
  logic                   busy;

  bytecode_translator_if #(.WORD_WIDTH(WORD_WIDTH)) bus ();

  bytecode_translator #(
    .WORD_WIDTH (WORD_WIDTH),
    .TADDR_WIDTH(TADDR_WIDTH),
    .MAX_PARAMS (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .lk_opcode     (lk_opcode),
    .lk_param_count(lk_param_count),
    .lk_template   (lk_template),
    .tmpl_addr     (tmpl_addr),
    .tmpl_word     (tmpl_word),
    .tmpl_next     (tmpl_next),
    .operand_valid (operand_valid),
    .operand_value (operand_value),
    .busy          (busy)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int accept_cyc = 0;
  logic [15:0] exp_ops[$];
  logic [31:0] exp_words[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Template ROM contents: word and link for each populated address
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'd3:    return 32'hE3A0_0001;
      8'd7:    return 32'hE280_0002;
      8'd10:   return 32'hE1A0_1000;
      8'd11:   return 32'hE12F_FF1E;
      8'd20:   return 32'hE590_1004;
      8'd30:   return 32'hE080_0001;
      8'd31:   return 32'hE040_0002;
      8'd32:   return 32'hE350_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] rom_next(input logic [7:0] a);
    case (a)
      8'd3:    return 8'd7;
      8'd10:   return 8'd11;
      8'd30:   return 8'd31;
      8'd31:   return 8'd32;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    tmpl_word = rom_word(tmpl_addr);
    tmpl_next = rom_next(tmpl_addr);
  end

  always_comb begin
    lk_param_count = 3'd0;
    lk_template    = 8'd0;
    case (lk_opcode)
      8'h60: begin lk_param_count = 3'd0; lk_template = 8'd3;  end
      8'h10: begin lk_param_count = 3'd1; lk_template = 8'd10; end
      8'h15: begin lk_param_count = 3'd1; lk_template = 8'd20; end
      8'h22: begin lk_param_count = 3'd2; lk_template = 8'd30; end
      8'hC4: begin lk_param_count = 3'd2; lk_template = 8'd0;  end
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: condition not met", name);
  endtask

  // Offer one byte and hold it until accepted; returns at posedge+1 after the transfer
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    while (!bus.byte_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.byte_ready) failNow("byte_accept_timeout");
    accept_cyc = cyc;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) failNow("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutValid();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) failNow("out_valid_timeout");
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (operand_valid) begin
        if (exp_ops.size() == 0) failNow("unexpected_operand");
        else checkOutput("operand_value", 32'(operand_value), 32'(exp_ops.pop_front()));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_words.size() == 0) failNow("unexpected_word");
        else checkOutput("out_word", bus.out_word, exp_words.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1;
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_operand_valid", 32'(operand_valid), 32'd0);
    checkOutput("rst_tmpl_addr", 32'(tmpl_addr), 32'd0);
    checkOutput("rst_lk_opcode", 32'(lk_opcode), 32'd0);
    checkOutput("rst_out_word", bus.out_word, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] zero-operand opcode 0x60, two-word template");
    exp_words.push_back(rom_word(8'd3));
    exp_words.push_back(rom_word(8'd7));
    applyStimulus(8'h60);
    waitOutValid();
    checkOutput("first_word_latency", 32'(cyc - accept_cyc), 32'd3);
    c1 = cyc;
    @(negedge clk);
    checkOutput("gap_out_valid", 32'(bus.out_valid), 32'd0);
    waitOutValid();
    checkOutput("next_word_latency", 32'(cyc - c1), 32'd2);
    waitIdle();

    $display("[TB] one 8-bit operand, opcode 0x10");
    exp_ops.push_back(16'h0085);
    exp_words.push_back(rom_word(8'd10));
    exp_words.push_back(rom_word(8'd11));
    applyStimulus(8'h10);
    applyStimulus(8'h85);
    waitIdle();

`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
    $display("[TB] wide prefix C4 15 01 02");
    exp_ops.push_back(16'h0102);
    exp_words.push_back(rom_word(8'd20));
    applyStimulus(8'hC4);
    applyStimulus(8'h15);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    waitIdle();

    $display("[TB] repeated wide prefix C4 C4 15 03 04");
    exp_ops.push_back(16'h0304);
    exp_words.push_back(rom_word(8'd20));
    applyStimulus(8'hC4);
    applyStimulus(8'hC4);
    applyStimulus(8'h15);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    waitIdle();

    $display("[TB] wide cleared: 0x10 0x85 takes one byte");
    exp_ops.push_back(16'h0085);
    exp_words.push_back(rom_word(8'd10));
    exp_words.push_back(rom_word(8'd11));
    applyStimulus(8'h10);
    applyStimulus(8'h85);
    waitIdle();
`else
    $display("[TB] C4 as ordinary opcode, two operands, empty template");
    exp_ops.push_back(16'h0015);
    exp_ops.push_back(16'h0001);
    applyStimulus(8'hC4);
    applyStimulus(8'h15);
    applyStimulus(8'h01);
    waitIdle();
    checkOutput("c4_tmpl_addr", 32'(tmpl_addr), 32'd0);
    checkOutput("c4_idle_ready", 32'(bus.byte_ready), 32'd1);
`endif

    $display("[TB] two operands, three-word template");
    exp_ops.push_back(16'h0007);
    exp_ops.push_back(16'h00FF);
    exp_words.push_back(rom_word(8'd30));
    exp_words.push_back(rom_word(8'd31));
    exp_words.push_back(rom_word(8'd32));
    applyStimulus(8'h22);
    applyStimulus(8'h07);
    applyStimulus(8'hFF);
    waitIdle();

    $display("[TB] downstream stall in EMIT");
    exp_words.push_back(rom_word(8'd3));
    exp_words.push_back(rom_word(8'd7));
    bus.out_ready = 1'b0;
    applyStimulus(8'h60);
    waitOutValid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall_out_word", bus.out_word, rom_word(8'd3));
      checkOutput("stall_byte_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("stall_tmpl_addr", 32'(tmpl_addr), 32'd3);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("release_tmpl_addr", 32'(tmpl_addr), 32'd7);
    waitIdle();

    $display("[TB] reset in the middle of operand fetch");
`ifdef BYTECODE_TRANSLATOR_WIDE_PREFIX_EN
    applyStimulus(8'hC4);
    applyStimulus(8'h15);
    applyStimulus(8'h01);
`else
    exp_ops.push_back(16'h00AA);
    applyStimulus(8'h22);
    applyStimulus(8'hAA);
`endif
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_operand_valid", 32'(operand_valid), 32'd0);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_tmpl_addr", 32'(tmpl_addr), 32'd0);
    checkOutput("midrst_lk_opcode", 32'(lk_opcode), 32'd0);
    checkOutput("midrst_operand_value", 32'(operand_value), 32'd0);
    checkOutput("midrst_out_word", bus.out_word, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ops.push_back(16'h0085);
    exp_words.push_back(rom_word(8'd10));
    exp_words.push_back(rom_word(8'd11));
    applyStimulus(8'h10);
    applyStimulus(8'h85);
    waitIdle();

    checkOutput("exp_ops_drained", 32'(exp_ops.size()), 32'd0);
    checkOutput("exp_words_drained", 32'(exp_words.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
